acc_alu: RTL

ACC_ALU -- requirements
Module: acc_alu

---
 rtl/acc_alu.sv | 121 ++++++++++++
 1 files changed

// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle logic/arithmetic ops and an 8-step shift-add multiply.
// Results update acc and {N,Z,C,V} flags and raise a one-cycle out_valid pulse.
module acc_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    output logic [3:0]       flags
);

    localparam int STEPW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_CLR
    } op_t;

    state_t                 state, state_nxt;
    op_t                    opc;
    logic                   accept;
    logic                   mul_last;
    logic [STEPW-1:0]       step;
    logic [2*WIDTH-1:0]     mcand, prod, prod_nxt;
    logic [WIDTH-1:0]       mplier;
    logic [WIDTH:0]         sum, diff;
    logic [WIDTH-1:0]       alu_res;
    logic                   alu_c, alu_v;

    assign opc      = op_t'(op);
    assign accept   = in_valid && in_ready;
    assign mul_last = (state == S_MUL) && (step == STEPW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) state_nxt = (opc == OP_MUL) ? S_MUL : S_DONE;
                else        state_nxt = S_IDLE;
            end
            S_MUL:   if (mul_last) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // DONE is entered only on a result edge and left one cycle later unless refilled.
    always_comb begin
        in_ready  = (state != S_MUL);
        out_valid = (state == S_DONE);
    end

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, operand};
        diff    = {1'b0, acc} - {1'b0, operand};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opc)
            OP_LOAD: alu_res = operand;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (acc[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (acc[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_AND:  alu_res = acc & operand;
            OP_OR:   alu_res = acc | operand;
            OP_XOR:  alu_res = acc ^ operand;
            default: alu_res = '0;
        endcase
    end

    assign prod_nxt = prod + (mplier[0] ? mcand : '0);

    // Multiplicand shifts left and multiplier right, so each step only tests mplier[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            flags  <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            step   <= '0;
        end else if (accept) begin
            if (opc == OP_MUL) begin
                mcand  <= {{WIDTH{1'b0}}, acc};
                mplier <= operand;
                prod   <= '0;
                step   <= '0;
            end else begin
                acc   <= alu_res;
                flags <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
        end else if (state == S_MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            prod   <= prod_nxt;
            step   <= step + 1'b1;
            if (mul_last) begin
                acc   <= prod_nxt[WIDTH-1:0];
                flags <= {prod_nxt[WIDTH-1], (prod_nxt[WIDTH-1:0] == '0),
                          (|prod_nxt[2*WIDTH-1:WIDTH]), 1'b0};
            end
        end
    end

endmodule
